// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer game datapath.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        REACT,
        DONE,
        CHEAT
    } state_t;

    localparam int RT_W             = 14;
    localparam int DLY_W            = 12;
    localparam int RND_W_DEF        = 11;
    localparam int MIN_DELAY_MS_DEF = 1000;
    localparam int MAX_RT_MS_DEF    = 9999;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for a raw push-button plus a registered
// one-cycle rising-edge pulse.
module btn_edge_sync (
    input  logic random_clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[0], btn};
        prev_d = sync_q[1];
        rise_d = sync_q[1] & ~prev_q;
    end

    always_ff @(posedge random_clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/reaction_timer_fsm.sv
// Round controller: random pre-stimulus delay, LED stimulus, reaction
// time measurement with cheat and timeout detection.
module reaction_timer_fsm
    import reaction_pkg::*;
#(
    parameter int MIN_DELAY_MS = MIN_DELAY_MS_DEF,
    parameter int MAX_RT_MS    = MAX_RT_MS_DEF,
    parameter int RND_W        = RND_W_DEF
) (
    input  logic             random_clk,
    input  logic             reset,
    input  logic             tick_ms,
    input  logic [RND_W-1:0] rnd_cnt,
    input  logic             start_btn,
    input  logic             react_btn,
    output logic             led,
    output logic [RT_W-1:0]  rt_ms,
    output logic             result_valid,
    output logic             cheat,
    output logic             timeout,
    output logic             busy
);

    logic start_rise;
    logic react_rise;

    btn_edge_sync u_start_sync (
        .random_clk (random_clk),
        .reset      (reset),
        .btn        (start_btn),
        .rise       (start_rise)
    );

    btn_edge_sync u_react_sync (
        .random_clk (random_clk),
        .reset      (reset),
        .btn        (react_btn),
        .rise       (react_rise)
    );

    state_t             state_q, state_d;
    logic [DLY_W-1:0]   delay_cnt_q, delay_cnt_d;
    logic [RT_W-1:0]    rt_cnt_q, rt_cnt_d;
    logic [RT_W-1:0]    rt_ms_q, rt_ms_d;
    logic               led_q, led_d;
    logic               valid_q, valid_d;
    logic               cheat_q, cheat_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        delay_cnt_d = delay_cnt_q;
        rt_cnt_d    = rt_cnt_q;
        rt_ms_d     = rt_ms_q;
        led_d       = led_q;
        valid_d     = valid_q;
        cheat_d     = cheat_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            IDLE, DONE, CHEAT: begin
                if (start_rise) begin
                    delay_cnt_d = DLY_W'(MIN_DELAY_MS) + DLY_W'(rnd_cnt);
                    rt_cnt_d    = '0;
                    rt_ms_d     = '0;
                    valid_d     = 1'b0;
                    cheat_d     = 1'b0;
                    timeout_d   = 1'b0;
                    led_d       = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // An early press beats a coinciding tick that would light the LED.
                if (react_rise) begin
                    cheat_d = 1'b1;
                    state_d = CHEAT;
                end else if (tick_ms) begin
                    if (delay_cnt_q == DLY_W'(1)) begin
                        led_d    = 1'b1;
                        rt_cnt_d = '0;
                        state_d  = REACT;
                    end else begin
                        delay_cnt_d = delay_cnt_q - DLY_W'(1);
                    end
                end
            end
            REACT: begin
                if (react_rise) begin
                    rt_ms_d = rt_cnt_q;
                    valid_d = 1'b1;
                    led_d   = 1'b0;
                    state_d = DONE;
                end else if (tick_ms) begin
                    if (rt_cnt_q == RT_W'(MAX_RT_MS - 1)) begin
                        rt_ms_d   = RT_W'(MAX_RT_MS);
                        timeout_d = 1'b1;
                        valid_d   = 1'b0;
                        led_d     = 1'b0;
                        state_d   = DONE;
                    end else begin
                        rt_cnt_d = rt_cnt_q + RT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == WAIT) || (state_d == REACT);
    end

    always_ff @(posedge random_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            delay_cnt_q <= '0;
            rt_cnt_q    <= '0;
            rt_ms_q     <= '0;
            led_q       <= 1'b0;
            valid_q     <= 1'b0;
            cheat_q     <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            delay_cnt_q <= delay_cnt_d;
            rt_cnt_q    <= rt_cnt_d;
            rt_ms_q     <= rt_ms_d;
            led_q       <= led_d;
            valid_q     <= valid_d;
            cheat_q     <= cheat_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign led          = led_q;
    assign rt_ms        = rt_ms_q;
    assign result_valid = valid_q;
    assign cheat        = cheat_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Directed bench for reaction_timer_fsm: normal round, cheat, timeout,
// coincident press/tick and asynchronous reset.
module tb_reaction_timer_fsm;

    logic        random_clk = 1'b0;
    logic        reset;
    logic        tick_ms;
    logic [10:0] rnd_cnt;
    logic        start_btn;
    logic        react_btn;
    logic        led;
    logic [13:0] rt_ms;
    logic        result_valid;
    logic        cheat;
    logic        timeout;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    reaction_timer_fsm dut (
        .random_clk   (random_clk),
        .reset        (reset),
        .tick_ms      (tick_ms),
        .rnd_cnt      (rnd_cnt),
        .start_btn    (start_btn),
        .react_btn    (react_btn),
        .led          (led),
        .rt_ms        (rt_ms),
        .result_valid (result_valid),
        .cheat        (cheat),
        .timeout      (timeout),
        .busy         (busy)
    );

    always #5 random_clk = ~random_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge random_clk);
        #1;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_ms = 1'b1;
            cyc();
            tick_ms = 1'b0;
            cyc();
        end
    endtask

    // Button goes high; the FSM reacts on the fourth edge after.
    // tick_last drives tick_ms during the cycle the FSM sees the rise.
    task automatic press(input bit is_react, input bit tick_last);
        if (is_react) react_btn = 1'b1;
        else          start_btn = 1'b1;
        cyc();
        cyc();
        cyc();
        tick_ms = tick_last;
        cyc();
        tick_ms = 1'b0;
    endtask

    task automatic release_all();
        start_btn = 1'b0;
        react_btn = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    initial begin
        reset     = 1'b1;
        tick_ms   = 1'b0;
        rnd_cnt   = 11'd500;
        start_btn = 1'b0;
        react_btn = 1'b0;
        cyc();
        cyc();
        chk("rst_led", led, 0);
        chk("rst_rt_ms", rt_ms, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_cheat", cheat, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        cyc();

        // react in IDLE is ignored
        press(1'b1, 1'b0);
        chk("idle_react_busy", busy, 0);
        chk("idle_react_cheat", cheat, 0);
        release_all();

        // Round 1: busy appears on the third edge after the first sample
        start_btn = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("start_busy_early", busy, 0);
        cyc();
        chk("start_busy", busy, 1);
        chk("start_led", led, 0);
        release_all();
        do_ticks(1499);
        chk("wait_1499_led", led, 0);
        chk("wait_1499_busy", busy, 1);
        do_ticks(1);
        chk("wait_1500_led", led, 1);
        do_ticks(237);
        press(1'b1, 1'b0);
        chk("rt237_rt_ms", rt_ms, 237);
        chk("rt237_valid", result_valid, 1);
        chk("rt237_led", led, 0);
        chk("rt237_busy", busy, 0);
        release_all();
        do_ticks(20);
        press(1'b1, 1'b0);
        chk("done_hold_rt_ms", rt_ms, 237);
        chk("done_hold_valid", result_valid, 1);
        chk("done_hold_busy", busy, 0);
        release_all();

        // Round 2: cheat after 300 of 1500 delay ticks
        press(1'b0, 1'b0);
        chk("r2_clear_valid", result_valid, 0);
        chk("r2_clear_rt_ms", rt_ms, 0);
        release_all();
        do_ticks(300);
        press(1'b1, 1'b0);
        chk("cheat_flag", cheat, 1);
        chk("cheat_led", led, 0);
        chk("cheat_valid", result_valid, 0);
        chk("cheat_busy", busy, 0);
        release_all();

        // Round 3: restart from CHEAT, then time out
        press(1'b0, 1'b0);
        chk("r3_cheat_clr", cheat, 0);
        chk("r3_busy", busy, 1);
        release_all();
        do_ticks(1500);
        chk("r3_led", led, 1);
        do_ticks(9998);
        chk("to_pre_timeout", timeout, 0);
        chk("to_pre_led", led, 1);
        do_ticks(1);
        chk("to_timeout", timeout, 1);
        chk("to_rt_ms", rt_ms, 9999);
        chk("to_led", led, 0);
        chk("to_valid", result_valid, 0);
        chk("to_busy", busy, 0);

        // Round 4: react and tick coincide with rt_cnt=42
        rnd_cnt = 11'd0;
        press(1'b0, 1'b0);
        chk("r4_timeout_clr", timeout, 0);
        release_all();
        do_ticks(1000);
        chk("r4_led", led, 1);
        do_ticks(42);
        press(1'b1, 1'b1);
        chk("coinc_rt_ms", rt_ms, 42);
        chk("coinc_valid", result_valid, 1);
        release_all();

        // Round 5: react and the lighting tick coincide in WAIT
        rnd_cnt = 11'd7;
        press(1'b0, 1'b0);
        release_all();
        do_ticks(1006);
        chk("r5_led_pre", led, 0);
        press(1'b1, 1'b1);
        chk("coinc_wait_cheat", cheat, 1);
        chk("coinc_wait_led", led, 0);
        chk("coinc_wait_busy", busy, 0);
        release_all();

        // Round 6: start held through WAIT, reset mid-REACT at rt_cnt=100
        rnd_cnt = 11'd500;
        press(1'b0, 1'b0);
        chk("r6_busy", busy, 1);
        do_ticks(1499);
        chk("r6_held_led_pre", led, 0);
        do_ticks(1);
        chk("r6_held_led", led, 1);
        do_ticks(100);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_led", led, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rt_ms", rt_ms, 0);
        chk("arst_valid", result_valid, 0);
        chk("arst_cheat", cheat, 0);
        chk("arst_timeout", timeout, 0);
        start_btn = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        do_ticks(5);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_led", led, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
